// File: rtl/uart_io_ctrl_pkg.sv
// Shared constants, status bit layout and TX scheduler states for uart_io_ctrl.
// Build option UART_IO_CTRL_TXFIFO_EN selects the circular TX FIFO over the single holding register.
package uart_io_ctrl_pkg;

  localparam logic [15:0] DEF_DATA_ADDR = 16'h1000;
  localparam logic [15:0] DEF_STAT_ADDR = 16'h2000;

  localparam int ST_TX_READY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_OVF   = 2;
  localparam int ST_RX_OVR   = 3;
  localparam int ST_TX_IDLE  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GUARD = 2'd2
  } tx_state_e;

  function automatic logic [15:0] pack_status(input logic tx_ready, input logic rx_full,
                                              input logic tx_ovf, input logic rx_ovr,
                                              input logic tx_idle);
    logic [15:0] s;
    s = 16'h0000;
    s[ST_TX_READY] = tx_ready;
    s[ST_RX_FULL]  = rx_full;
    s[ST_TX_OVF]   = tx_ovf;
    s[ST_RX_OVR]   = rx_ovr;
    s[ST_TX_IDLE]  = tx_idle;
    return s;
  endfunction

endpackage

// File: rtl/uart_io_txfifo.sv
// TX byte buffer: circular FIFO of 2^DEPTH_LOG2 entries with UART_IO_CTRL_TXFIFO_EN,
// otherwise a single holding register. A push into a full buffer is accepted only when a pop frees a slot.
module uart_io_txfifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  logic push_ok_s;
  logic pop_ok_s;

`ifdef UART_IO_CTRL_TXFIFO_EN
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;

  assign full      = (count_r == (DEPTH_LOG2+1)'(DEPTH));
  assign empty     = (count_r == (DEPTH_LOG2+1)'(0));
  assign head      = mem_r[rd_ptr_r];
  assign push_ok_s = push && (!full || pop);
  assign pop_ok_s  = pop && !empty;

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (DEPTH_LOG2+1)'(1);
        2'b01:   count_r <= count_r - (DEPTH_LOG2+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end
`else
  localparam int unused_depth_log2 = DEPTH_LOG2;

  logic [7:0] data_r;
  logic       valid_r;

  assign full      = valid_r;
  assign empty     = !valid_r;
  assign head      = data_r;
  assign push_ok_s = push && (!valid_r || pop);
  assign pop_ok_s  = pop && valid_r;

  // Single holding register; a same-cycle pop and push keeps it occupied.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      data_r  <= 8'h00;
      valid_r <= 1'b0;
    end else begin
      if (push_ok_s) data_r <= din;
      case ({push_ok_s, pop_ok_s})
        2'b10, 2'b11: valid_r <= 1'b1;
        2'b01:        valid_r <= 1'b0;
        default:      valid_r <= valid_r;
      endcase
    end
  end
`endif

endmodule

// File: rtl/uart_io_ctrl.sv
// j1 I/O bus to buart bridge: data/status registers, buffered TX with IDLE/ISSUE/GUARD scheduler, RX capture.
// UART_IO_CTRL_TXFIFO_EN enables a 2^TXDEPTH_LOG2-entry TX FIFO instead of one holding register.
module uart_io_ctrl
  import uart_io_ctrl_pkg::*;
#(
  parameter int          TXDEPTH_LOG2 = 3,
  parameter logic [15:0] DATA_ADDR    = DEF_DATA_ADDR,
  parameter logic [15:0] STAT_ADDR    = DEF_STAT_ADDR
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  output logic        uart_wr,
  output logic [7:0]  uart_tx_data,
  output logic        uart_rd,
  input  logic        uart_busy,
  input  logic        uart_valid,
  input  logic [7:0]  uart_rx_data
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_GUARD = GUARD;

  logic        wr_data_s, wr_stat_s, rd_data_s, rd_stat_s;
  logic        full_s, empty_s, pop_s, capture_s;
  logic [7:0]  head_s;
  logic [1:0]  state_r, state_nxt_s;
  logic        tx_ovf_r, rx_ovr_r, rx_full_r;
  logic [7:0]  rx_byte_r;
  logic [15:0] status_s;
  logic        unused_s;

  assign wr_data_s = io_wr && (io_addr == DATA_ADDR);
  assign wr_stat_s = io_wr && (io_addr == STAT_ADDR);
  assign rd_data_s = io_rd && (io_addr == DATA_ADDR);
  assign rd_stat_s = io_rd && (io_addr == STAT_ADDR);
  assign capture_s = uart_valid && !uart_rd;
  assign unused_s  = ^io_wdata[15:8];

  assign status_s = pack_status(!full_s, rx_full_r, tx_ovf_r, rx_ovr_r,
                                empty_s && (state_r == S_IDLE) && !uart_busy);

  uart_io_txfifo #(.DEPTH_LOG2(TXDEPTH_LOG2)) u_txfifo (
    .clk   (clk),
    .resetq(resetq),
    .push  (wr_data_s),
    .pop   (pop_s),
    .din   (io_wdata[7:0]),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

  // Scheduler next state; GUARD ignores uart_busy to cover buart's busy-rise latency.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!empty_s && !uart_busy) begin
          pop_s       = 1'b1;
          state_nxt_s = S_ISSUE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE: state_nxt_s = S_GUARD;
      S_GUARD: state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // TX state, strobe and byte; uart_wr is high exactly while the FSM sits in ISSUE.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_r      <= S_IDLE;
      uart_wr      <= 1'b0;
      uart_tx_data <= 8'h00;
      tx_ovf_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      uart_wr <= pop_s;
      if (pop_s) uart_tx_data <= head_s;
      if (wr_data_s && full_s && !pop_s) begin
        tx_ovf_r <= 1'b1;
      end else if (wr_stat_s && io_wdata[ST_TX_OVF]) begin
        tx_ovf_r <= 1'b0;
      end
    end
  end

  // RX capture; a CPU data read in the capture cycle consumes the old byte, so no overrun.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      uart_rd   <= 1'b0;
      rx_byte_r <= 8'h00;
      rx_full_r <= 1'b0;
      rx_ovr_r  <= 1'b0;
    end else begin
      uart_rd <= capture_s;
      if (capture_s) rx_byte_r <= uart_rx_data;
      if (capture_s) begin
        rx_full_r <= 1'b1;
      end else if (rd_data_s) begin
        rx_full_r <= 1'b0;
      end
      if (capture_s && rx_full_r && !rd_data_s) begin
        rx_ovr_r <= 1'b1;
      end else if (wr_stat_s && io_wdata[ST_RX_OVR]) begin
        rx_ovr_r <= 1'b0;
      end
    end
  end

  // Read data register holds its value until the next io_rd.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      io_rdata <= 16'h0000;
    end else if (rd_data_s) begin
      io_rdata <= {8'h00, rx_byte_r};
    end else if (rd_stat_s) begin
      io_rdata <= status_s;
    end else if (io_rd) begin
      io_rdata <= 16'h0000;
    end
  end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Self-checking bench for uart_io_ctrl: randomized bytes checked against a queue-based reference model.
module tb_uart_io_ctrl;

  localparam logic [15:0] DA = 16'h1000;
  localparam logic [15:0] SA = 16'h2000;
`ifdef UART_IO_CTRL_TXFIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0, resetq = 1'b0;
  logic        io_rd = 1'b0, io_wr = 1'b0, uart_busy = 1'b0, uart_valid = 1'b0;
  logic [15:0] io_addr = 16'h0000, io_wdata = 16'h0000;
  logic [7:0]  uart_rx_data = 8'h00;
  logic [15:0] io_rdata;
  logic        uart_wr, uart_rd;
  logic [7:0]  uart_tx_data;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] mon_q[$];
  int         mon_t[$];
  logic [7:0] model_q[$];

  uart_io_ctrl #(.TXDEPTH_LOG2(3), .DATA_ADDR(DA), .STAT_ADDR(SA)) dut (
    .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .uart_wr(uart_wr), .uart_tx_data(uart_tx_data),
    .uart_rd(uart_rd), .uart_busy(uart_busy), .uart_valid(uart_valid), .uart_rx_data(uart_rx_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (resetq && uart_wr) begin
      mon_q.push_back(uart_tx_data);
      mon_t.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    io_addr = a; io_wdata = d; io_wr = 1'b1;
    tick();
    io_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
    io_addr = a; io_rd = 1'b1;
    tick();
    io_rd = 1'b0;
    d = io_rdata;
  endtask

  function automatic logic [15:0] exp_stat(input bit ready, input bit full, input bit ovf,
                                           input bit ovr, input bit idle);
    return {11'd0, idle, ovr, ovf, full, ready};
  endfunction

  task automatic test_reset();
    logic [15:0] r;
    logic [7:0] b;
    resetq = 1'b0;
    tick(); tick();
    n_checks++; if (uart_wr !== 1'b0) begin n_fail++; $display("FAIL reset_uart_wr got %b exp 0", uart_wr); end
    n_checks++; if (uart_rd !== 1'b0) begin n_fail++; $display("FAIL reset_uart_rd got %b exp 0", uart_rd); end
    n_checks++; if (io_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_io_rdata got %h exp 0000", io_rdata); end
    n_checks++; if (uart_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h exp 00", uart_tx_data); end
    resetq = 1'b1;
    tick();
    b = 8'($urandom_range(1, 255));
    cpu_write(DA, {8'h00, b});
    tick();
    n_checks++; if (uart_wr !== 1'b1) begin n_fail++; $display("FAIL pre_reset_issue got %b exp 1", uart_wr); end
    #2 resetq = 1'b0;
    #1;
    n_checks++; if (uart_wr !== 1'b0) begin n_fail++; $display("FAIL reset_async_wr got %b exp 0", uart_wr); end
    n_checks++; if (uart_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_async_data got %h exp 00", uart_tx_data); end
    tick();
    resetq = 1'b1;
    tick();
    mon_q.delete(); mon_t.delete();
    cpu_read(SA, r);
    n_checks++; if (r !== 16'h0011) begin n_fail++; $display("FAIL reset_status got %h exp 0011", r); end
  endtask

  task automatic test_tx_single();
    logic [15:0] r;
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      b = (k == 0) ? 8'h41 : 8'($urandom);
      cpu_write(DA, {8'($urandom), b});
      n_checks++; if (uart_wr !== 1'b0) begin n_fail++; $display("FAIL tx_lat_n1 got %b exp 0", uart_wr); end
      tick();
      n_checks++; if (uart_wr !== 1'b1 || uart_tx_data !== b) begin
        n_fail++; $display("FAIL tx_lat_n2 got wr=%b data=%h exp wr=1 data=%h", uart_wr, uart_tx_data, b);
      end
      tick();
      n_checks++; if (uart_wr !== 1'b0) begin n_fail++; $display("FAIL tx_one_cycle got %b exp 0", uart_wr); end
      tick(); tick();
      cpu_read(SA, r);
      n_checks++; if (r !== 16'h0011) begin n_fail++; $display("FAIL tx_status_after got %h exp 0011", r); end
    end
    mon_q.delete(); mon_t.delete();
    cpu_write(16'h3000, 16'hFFFF);
    tick(); tick(); tick();
    n_checks++; if (mon_q.size() != 0) begin n_fail++; $display("FAIL other_addr_write got %0d pulses exp 0", mon_q.size()); end
  endtask

  task automatic test_tx_overflow();
    logic [15:0] r;
    logic [7:0] b;
    uart_busy = 1'b1;
    model_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      cpu_write(DA, {8'h00, b});
      model_q.push_back(b);
      cpu_read(SA, r);
      n_checks++; if (r !== exp_stat(model_q.size() < DEPTH, 1'b0, 1'b0, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL ovf_fill_%0d got %h exp %h", i, r, exp_stat(model_q.size() < DEPTH, 1'b0, 1'b0, 1'b0, 1'b0));
      end
    end
    cpu_write(DA, {8'h00, 8'($urandom)});
    cpu_read(SA, r);
    n_checks++; if (r !== 16'h0004) begin n_fail++; $display("FAIL ovf_set got %h exp 0004", r); end
    cpu_write(SA, 16'h0004);
    cpu_read(SA, r);
    n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL ovf_w1c got %h exp 0000", r); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r;
    logic [7:0] b;
    bit ovf;
    for (int round = 0; round < 2; round++) begin
      ovf = 1'b0;
      if (round == 1) begin
        uart_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
          b = 8'($urandom);
          cpu_write(DA, {8'h00, b});
          if (model_q.size() < DEPTH) model_q.push_back(b);
          else ovf = 1'b1;
        end
      end
      mon_q.delete(); mon_t.delete();
      uart_busy = 1'b0;
      for (int i = 0; i < 200 && mon_q.size() < model_q.size(); i++) tick();
      tick(); tick(); tick(); tick(); tick(); tick();
      n_checks++; if (mon_q.size() != model_q.size()) begin
        n_fail++; $display("FAIL b2b_count round %0d got %0d exp %0d", round, mon_q.size(), model_q.size());
      end
      for (int i = 0; i < mon_q.size() && i < model_q.size(); i++) begin
        n_checks++; if (mon_q[i] !== model_q[i]) begin
          n_fail++; $display("FAIL b2b_order[%0d] got %h exp %h", i, mon_q[i], model_q[i]);
        end
        if (i > 0) begin
          n_checks++; if (mon_t[i] - mon_t[i-1] != 3) begin
            n_fail++; $display("FAIL b2b_spacing[%0d] got %0d exp 3", i, mon_t[i] - mon_t[i-1]);
          end
        end
      end
      model_q.delete();
      cpu_read(SA, r);
      n_checks++; if (r !== exp_stat(1'b1, 1'b0, ovf, 1'b0, 1'b1)) begin
        n_fail++; $display("FAIL b2b_status got %h exp %h", r, exp_stat(1'b1, 1'b0, ovf, 1'b0, 1'b1));
      end
      cpu_write(SA, 16'h0004);
    end
  endtask

  task automatic test_rx();
    logic [15:0] r;
    logic [7:0] b;
    for (int k = 0; k < 3; k++) begin
      b = (k == 0) ? 8'h5A : 8'($urandom);
      uart_rx_data = b; uart_valid = 1'b1;
      tick();
      uart_valid = 1'b0;
      n_checks++; if (uart_rd !== 1'b1) begin n_fail++; $display("FAIL rx_rd_pulse got %b exp 1", uart_rd); end
      tick();
      n_checks++; if (uart_rd !== 1'b0) begin n_fail++; $display("FAIL rx_rd_one got %b exp 0", uart_rd); end
      cpu_read(SA, r);
      n_checks++; if (r !== 16'h0013) begin n_fail++; $display("FAIL rx_full_status got %h exp 0013", r); end
      cpu_read(DA, r);
      n_checks++; if (r !== {8'h00, b}) begin n_fail++; $display("FAIL rx_data got %h exp %h", r, {8'h00, b}); end
      tick(); tick(); tick();
      n_checks++; if (io_rdata !== {8'h00, b}) begin n_fail++; $display("FAIL rdata_hold got %h exp %h", io_rdata, {8'h00, b}); end
      cpu_read(SA, r);
      n_checks++; if (r !== 16'h0011) begin n_fail++; $display("FAIL rx_cleared got %h exp 0011", r); end
    end
    cpu_read(16'h3000, r);
    n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL other_addr_read got %h exp 0000", r); end
  endtask

  task automatic test_rx_overrun();
    logic [15:0] r;
    uart_rx_data = 8'h11; uart_valid = 1'b1;
    tick();
    uart_valid = 1'b0;
    tick();
    uart_rx_data = 8'h22; uart_valid = 1'b1;
    io_addr = SA; io_wdata = 16'h0008; io_wr = 1'b1;
    tick();
    uart_valid = 1'b0; io_wr = 1'b0;
    tick();
    cpu_read(SA, r);
    n_checks++; if (r !== 16'h001B) begin n_fail++; $display("FAIL ovr_set_wins got %h exp 001B", r); end
    cpu_read(DA, r);
    n_checks++; if (r !== 16'h0022) begin n_fail++; $display("FAIL ovr_data got %h exp 0022", r); end
    cpu_write(SA, 16'h0008);
    cpu_read(SA, r);
    n_checks++; if (r !== 16'h0011) begin n_fail++; $display("FAIL ovr_w1c got %h exp 0011", r); end
  endtask

  task automatic test_rx_simul();
    logic [15:0] r;
    logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    uart_rx_data = b1; uart_valid = 1'b1;
    tick();
    uart_valid = 1'b0;
    tick();
    uart_rx_data = b2; uart_valid = 1'b1;
    io_addr = DA; io_rd = 1'b1;
    tick();
    uart_valid = 1'b0; io_rd = 1'b0;
    n_checks++; if (io_rdata !== {8'h00, b1}) begin n_fail++; $display("FAIL simul_old_byte got %h exp %h", io_rdata, {8'h00, b1}); end
    n_checks++; if (uart_rd !== 1'b1) begin n_fail++; $display("FAIL simul_rd got %b exp 1", uart_rd); end
    tick();
    cpu_read(SA, r);
    n_checks++; if (r !== 16'h0013) begin n_fail++; $display("FAIL simul_status got %h exp 0013", r); end
    cpu_read(DA, r);
    n_checks++; if (r !== {8'h00, b2}) begin n_fail++; $display("FAIL simul_new_byte got %h exp %h", r, {8'h00, b2}); end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_tx_overflow();
    test_back_to_back();
    test_rx();
    test_rx_overrun();
    test_rx_simul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_io_ctrl.md
# uart_io_ctrl

Memory-mapped controller between the j1 I/O bus and the `buart` UART. It decodes CPU `io_rd`/`io_wr` cycles into data and status registers, and buffers transmit bytes. A three-state scheduler issues them to the UART only when it is not busy. It also captures received bytes and reports overrun and overflow conditions, replacing the direct `io_wr`-to-`wr` hookup at top level.

## Interface
- `TXDEPTH_LOG2`, 3: log2 of TX FIFO depth (FIFO build only).
- `DATA_ADDR`, 16'h1000: data register address.
- `STAT_ADDR`, 16'h2000: status register address.

- `clk`  in  1  system clock.
- `resetq`  in  1  reset; asynchronous, active-low.
- `io_rd`  in  1  CPU I/O read strobe, one cycle.
- `io_wr`  in  1  CPU I/O write strobe, one cycle.
- `io_addr`  in  16  CPU I/O address (`mem_addr`).
- `io_wdata`  in  16  CPU write data (`dout`).
- `io_rdata`  out  16  read data to CPU (`io_din`).
- `uart_wr`  out  1  one-cycle transmit strobe to `buart`.
- `uart_tx_data`  out  8  byte for `uart_wr`.
- `uart_rd`  out  1  one-cycle acknowledge of a received byte.
- `uart_busy`  in  1  transmitter busy.
- `uart_valid`  in  1  received byte available.
- `uart_rx_data`  in  8  received byte.

## Operation
- Write to `DATA_ADDR`:
  - `io_wdata[7:0]` is pushed to the TX buffer.
  - If the buffer is full and nothing pops that cycle, the byte is dropped and sticky `tx_ovf` is set.
- Write to `STAT_ADDR`: write-1-to-clear. `io_wdata[2]` clears `tx_ovf`; `io_wdata[3]` clears `rx_ovr`.
- Read from `DATA_ADDR`: returns `{8'h00, rx_byte}` and clears `rx_full`.
- Read from `STAT_ADDR`: returns `{11'b0, tx_idle, rx_ovr, tx_ovf, rx_full, tx_ready}`.
  - `tx_ready` = buffer not full.
  - `tx_idle` = buffer empty, FSM in `IDLE`, and `!uart_busy`.
- Reads from other addresses return 16'h0000. Writes to other addresses are ignored.
- TX scheduler FSM:
  - `IDLE`: if the buffer is non-empty and `!uart_busy`, pop the head into `uart_tx_data` and go to `ISSUE`.
  - `ISSUE`: assert `uart_wr` for exactly one cycle, then go to `GUARD`.
  - `GUARD`: one cycle, ignoring `uart_busy` to cover `buart`'s busy-rise latency, then go to `IDLE`.
- RX capture:
  - On `uart_valid` while `uart_rd` is low: latch `uart_rx_data` into `rx_byte`, set `rx_full`, and pulse `uart_rd` on the next cycle.
  - If `rx_full` is already set and no CPU data read occurs that cycle, the byte overwrites `rx_byte` and `rx_ovr` is set.
- Simultaneous events:
  - TX push and pop in the same cycle while full: the push is accepted, and the count is unchanged.
  - RX capture and CPU data read in the same cycle: the CPU gets the old byte, the new byte is latched, `rx_full` stays 1, and there is no overrun.
  - Sticky set and W1C in the same cycle: set wins.

## Timing
- Reset values:
  - `uart_wr`, `uart_rd`, `io_rdata`, `uart_tx_data`, `rx_byte` all 0.
  - FSM in `IDLE`; buffer empty.
  - `rx_full`, `tx_ovf`, `rx_ovr` all 0.
- Reset asserted mid-transmit drops `uart_wr` immediately and discards buffered bytes.
- `io_rdata` is registered and valid the cycle after `io_rd`. It holds until the next `io_rd`.
- Write-to-`uart_wr` latency, empty buffer and UART idle: push at cycle N, `IDLE` pops at N+1, `uart_wr` high at N+2.
- Minimum spacing between `uart_wr` pulses: 3 cycles.
- `uart_rd` is high exactly one cycle after each captured `uart_valid` cycle.
- Buffer pointers wrap modulo depth. Occupancy counter width is `TXDEPTH_LOG2+1`.

## Configuration
- `UART_IO_CTRL_TXFIFO_EN` defined:
  - TX buffer is a circular FIFO of 2^`TXDEPTH_LOG2` entries.
- Undefined:
  - TX buffer is a single holding register, so `tx_ready` is 0 while it is occupied.
  - FSM and status behaviour are otherwise identical.
  - `TXDEPTH_LOG2` is ignored.

## Structure
- `uart_io_ctrl_pkg`:
  - default address constants;
  - status bit indices (`ST_TX_READY`=0, `ST_RX_FULL`=1, `ST_TX_OVF`=2, `ST_RX_OVR`=3, `ST_TX_IDLE`=4);
  - TX FSM state enum (`IDLE`, `ISSUE`, `GUARD`).
- One sub-module, `uart_io_txfifo`: synchronous FIFO with push/pop/full/empty/head. It collapses to one entry without the macro.

## Test plan
- Reset with `resetq` low mid-`ISSUE` -> `uart_wr`=0 at once; after release, status read = 16'h0011 (`tx_ready`, `tx_idle`).
- Write 8'h41 to 16'h1000, `uart_busy`=0 -> `uart_wr` pulses one cycle at N+2 with `uart_tx_data`=8'h41; status returns to 16'h0011.
- FIFO build, `uart_busy` held 1, write 9 bytes with depth 8 -> `tx_ready`=0 after the 8th; 9th sets `tx_ovf` (status 16'h0004); W1C 16'h0004 clears it.
- `uart_valid` with 8'h5A -> `uart_rd` pulses next cycle and status bit1=1; read 16'h1000 returns 16'h005A, and bit1 clears.
- Two `uart_valid` bytes 8'h11 then 8'h22 with no read -> `rx_ovr`=1 and data read returns 16'h0022.
- Release `uart_busy` with 3 queued bytes -> `uart_wr` pulses exactly 3 cycles apart, in FIFO order.
